seg7_scan_driver: RTL

Time-multiplexed driver for an 8-digit, common-anode seven-segment display. It consumes the processor's 32-bit `seg_display` result word and shows it as 8 hex digits, one digit per refresh slot. The word is snapshotted once per scan frame so the display never tears mid-frame. It sits between the processor top level and the board display pins.

---
 rtl/seg7_scan_driver.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 8-digit hex driver for a common-anode seven-segment display

module seg7_scan_driver #(
   parameter int CLK_DIV  = 100000,
   parameter int GUARD    = 4,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] value,
   input  logic        hold,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_done
);

   localparam int                CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  GUARD_END = CNT_W'(GUARD);

   localparam logic [7:0] AN_OFF  = 8'hFF;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Scan state
   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]       dig_q,     dig_d;
   logic [31:0]      snap_q,    snap_d;

   // Registered outputs
   logic [7:0]       an_q,         an_d;
   logic [6:0]       seg_q,        seg_d;
   logic             frame_done_q, frame_done_d;

   // Decode helpers
   logic             tick;
   logic             boundary;
   logic [4:0]       shamt;
   logic [31:0]      snap_shift;
   logic [3:0]       nib;
   logic             lz;
   logic             in_guard;

   // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Slot timing, digit selection and leading-zero detection from the current scan state
   always_comb begin
      tick       = (div_cnt_q == DIV_LAST);
      boundary   = tick && (dig_q == 3'd7);
      shamt      = {dig_q, 2'b00};
      // Everything at and above the current digit, right-aligned: its low nibble is the
      // digit itself, and it is zero exactly when this digit is a leading zero.
      snap_shift = snap_q >> shamt;
      nib        = snap_shift[3:0];
      lz         = BLANK_LZ && (dig_q != 3'd0) && (snap_shift == 32'd0);
      in_guard   = (div_cnt_q < GUARD_END);
   end

   // Next-state: divider, digit counter, frame snapshot and the output word for the next cycle
   always_comb begin
      div_cnt_d    = div_cnt_q + CNT_W'(1);
      dig_d        = dig_q;
      snap_d       = snap_q;
      an_d         = AN_OFF;
      seg_d        = SEG_OFF;
      frame_done_d = 1'b0;

      if (tick) begin
         div_cnt_d = '0;
         dig_d     = dig_q + 3'd1;
      end

      // The snapshot only moves on the frame boundary so a frame never mixes two words
      if (boundary) begin
         frame_done_d = 1'b1;
         if (!hold) begin
            snap_d = value;
         end
      end

      // Anodes stay dark at the start of every slot to hide the previous digit's pattern
      if (!in_guard && !lz) begin
         an_d  = ~(8'd1 << dig_q);
         seg_d = hex_decode(nib);
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt_q    <= '0;
         dig_q        <= 3'd0;
         snap_q       <= 32'd0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         dig_q        <= dig_d;
         snap_q       <= snap_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = 1'b1;
   assign frame_done = frame_done_q;

endmodule
